// File: rtl/hub75_pkg.sv
// -----------------------------------------------------------------------------
// hub75_pkg
// Shared types and sizing helpers for the HUB75 output stage.
//   hub75_bcm_state_t : states of the BCM display scheduler
//   out_rows()        : physical row count driven per segment
//   pix_bit_width()   : width of a bit-plane index
//   addr_width()      : width of the HUB75 row address (A..E)
// -----------------------------------------------------------------------------
package hub75_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE_BLANK,
      LATCH,
      POST_BLANK,
      DISPLAY,
      STALL
   } hub75_bcm_state_t;

   function automatic int out_rows(input int vpixel, input int segments);
      return vpixel / segments;
   endfunction

   function automatic int pix_bit_width(input int bpp);
      return (bpp > 1) ? $clog2(bpp) : 1;
   endfunction

   function automatic int addr_width(input int rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage

// File: rtl/hub75_down_counter.sv
// -----------------------------------------------------------------------------
// hub75_down_counter
// Loadable down-counter with a zero flag. A load of N-1 followed by
// decrements gives a phase of exactly N cycles, ending on the cycle where
// zero is high.
//   clk, rst   : clock, synchronous active-high reset
//   load       : load load_value (has priority over dec)
//   load_value : value to load
//   dec        : decrement by one; saturates at zero
//   zero       : count is zero
// -----------------------------------------------------------------------------
module hub75_down_counter #(
   parameter int width_p = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [width_p-1:0] load_value,
   input  logic               dec,
   output logic               zero
);

   logic [width_p-1:0] count;

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - width_p'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/hub75_bcm_timer.sv
// -----------------------------------------------------------------------------
// hub75_bcm_timer
// Binary-coded-modulation scheduler for the HUB75 output stage. For every
// line the shift datapath offers it blanks the panel, pulses LAT, updates the
// row address, blanks again and then enables the LEDs for
// max(base_cycles,1) << pix_bit cycles.
//   clk, rst       : clock, synchronous active-high reset
//   i_en           : timer enable from hub75_control
//   i_line_valid   : shift register holds a complete line (level)
//   i_pix_bit      : bit plane of the pending line
//   i_base_cycles  : display cycles for plane 0 (0 behaves as 1)
//   o_line_ack     : one-cycle pulse, line latched and shift register free
//   o_lat          : HUB75 LAT
//   o_oe_n         : HUB75 OE, active low
//   o_addr         : HUB75 row address
//   o_blanking     : copy of o_oe_n for hub75_control
//   o_underflow    : one-cycle pulse when a display period ends unfed
// All outputs are registered.
// -----------------------------------------------------------------------------
module hub75_bcm_timer
   import hub75_pkg::*;
#(
   parameter int vpixel_p   = 64,
   parameter int segments_p = 2,
   parameter int bpp_p      = 8,
   parameter int base_wd_p  = 16,
   parameter int dead_p     = 4
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic                                               i_en,
   input  logic                                               i_line_valid,
   input  logic [pix_bit_width(bpp_p)-1:0]                    i_pix_bit,
   input  logic [base_wd_p-1:0]                               i_base_cycles,
   output logic                                               o_line_ack,
   output logic                                               o_lat,
   output logic                                               o_oe_n,
   output logic [addr_width(out_rows(vpixel_p,segments_p))-1:0] o_addr,
   output logic                                               o_blanking,
   output logic                                               o_underflow
);

   localparam int out_rows_p      = out_rows(vpixel_p, segments_p);
   localparam int pix_bit_width_p = pix_bit_width(bpp_p);
   localparam int addr_wd_p       = addr_width(out_rows_p);
   // Widest on-time is (2^base_wd_p - 1) << (bpp_p - 1), so this never wraps.
   localparam int cnt_wd_p        = base_wd_p + bpp_p - 1;

   hub75_bcm_state_t           state;
   logic                       first;
   logic [pix_bit_width_p-1:0] bit_q;
   logic [base_wd_p-1:0]       base_q;

   logic                cnt_load;
   logic                cnt_dec;
   logic                cnt_zero;
   logic [cnt_wd_p-1:0] cnt_value;
   logic [cnt_wd_p-1:0] dead_value;
   logic [cnt_wd_p-1:0] display_value;

   // Phases of length N load N-1 and end when the counter reads zero.
   assign dead_value    = cnt_wd_p'(dead_p - 1);
   assign display_value = (cnt_wd_p'(base_q) << bit_q) - cnt_wd_p'(1);

   // The one counter is reloaded at every phase boundary: dead time on line
   // acceptance and after LATCH, the display length once post-blank expires.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      cnt_value = dead_value;
      case (state)
         IDLE, STALL: cnt_load = i_en && i_line_valid;
         PRE_BLANK:   cnt_dec  = !cnt_zero;
         LATCH:       cnt_load = 1'b1;
         POST_BLANK: begin
            if (cnt_zero) begin
               cnt_load  = 1'b1;
               cnt_value = display_value;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         DISPLAY: begin
            if (cnt_zero) cnt_load = i_en && i_line_valid;
            else          cnt_dec  = 1'b1;
         end
         default: ;
      endcase
   end

   hub75_down_counter #(
      .width_p (cnt_wd_p)
   ) u_counter (
      .clk        (clk),
      .rst        (rst),
      .load       (cnt_load),
      .load_value (cnt_value),
      .dec        (cnt_dec),
      .zero       (cnt_zero)
   );

   // Outputs are set on the transition into a state, so o_lat/o_line_ack are
   // high exactly during LATCH and o_oe_n is low exactly during DISPLAY.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         first       <= 1'b1;
         bit_q       <= '0;
         base_q      <= base_wd_p'(1);
         o_addr      <= '0;
         o_oe_n      <= 1'b1;
         o_lat       <= 1'b0;
         o_line_ack  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         o_lat       <= 1'b0;
         o_line_ack  <= 1'b0;
         o_underflow <= 1'b0;
         case (state)
            IDLE: begin
               if (i_en && i_line_valid) state <= PRE_BLANK;
            end
            PRE_BLANK: begin
               if (cnt_zero) begin
                  state      <= LATCH;
                  o_lat      <= 1'b1;
                  o_line_ack <= 1'b1;
               end
            end
            LATCH: begin
               bit_q  <= i_pix_bit;
               base_q <= (i_base_cycles == '0) ? base_wd_p'(1) : i_base_cycles;
               // Plane 0 opens a new row, except for the very first line
               // after enable, which belongs to row 0.
               if ((i_pix_bit == '0) && !first) begin
                  o_addr <= (o_addr == addr_wd_p'(out_rows_p - 1)) ? '0
                                                                    : o_addr + addr_wd_p'(1);
               end
               first <= 1'b0;
               state <= POST_BLANK;
            end
            POST_BLANK: begin
               if (cnt_zero) begin
                  state  <= DISPLAY;
                  o_oe_n <= 1'b0;
               end
            end
            DISPLAY: begin
               if (cnt_zero) begin
                  o_oe_n <= 1'b1;
                  if (!i_en) begin
                     state <= IDLE;
                     first <= 1'b1;
                  end else if (i_line_valid) begin
                     state <= PRE_BLANK;
                  end else begin
                     state       <= STALL;
                     o_underflow <= 1'b1;
                  end
               end
            end
            STALL: begin
               if (i_en && i_line_valid) state <= PRE_BLANK;
               else if (!i_en)           state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_blanking = o_oe_n;

endmodule

// File: tb/tb_hub75_bcm_timer.sv
// -----------------------------------------------------------------------------
// tb_hub75_bcm_timer
// Self-checking bench for hub75_bcm_timer with default parameters
// (32 rows, 8 planes, dead time 4). A reference model expands each accepted
// line into its expected output waveform (blank, LAT, blank, display) and a
// compare process checks every cycle against it; directed scenarios pin
// latencies, on-times and the row sequence with literal values.
// -----------------------------------------------------------------------------
module tb_hub75_bcm_timer;

   localparam int DEAD     = 4;
   localparam int OUT_ROWS = 32;
   localparam int MAX_WAIT = 3000;

   logic        clk;
   logic        rst;
   logic        i_en;
   logic        i_line_valid;
   logic [2:0]  i_pix_bit;
   logic [15:0] i_base_cycles;
   logic        o_line_ack;
   logic        o_lat;
   logic        o_oe_n;
   logic [4:0]  o_addr;
   logic        o_blanking;
   logic        o_underflow;

   hub75_bcm_timer dut (
      .clk           (clk),
      .rst           (rst),
      .i_en          (i_en),
      .i_line_valid  (i_line_valid),
      .i_pix_bit     (i_pix_bit),
      .i_base_cycles (i_base_cycles),
      .o_line_ack    (o_line_ack),
      .o_lat         (o_lat),
      .o_oe_n        (o_oe_n),
      .o_addr        (o_addr),
      .o_blanking    (o_blanking),
      .o_underflow   (o_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass   = 0;
   int n_checks = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------------------------------------------------------- model
   typedef struct packed {
      logic       oe_n;
      logic       lat;
      logic       ack;
      logic       uf;
      logic [4:0] addr;
      logic       chk_addr;
   } exp_t;

   typedef enum {M_IDLE, M_STALL, M_RUN} mode_t;

   exp_t  exp_q[$];
   exp_t  exp_now;
   mode_t mode;
   bit    m_first;
   int    m_addr;

   function automatic exp_t mk(logic oe, logic lat, logic ack, logic uf, int a, logic chk);
      exp_t e;
      e.oe_n = oe; e.lat = lat; e.ack = ack; e.uf = uf;
      e.addr = 5'(a); e.chk_addr = chk;
      return e;
   endfunction

   // Expand one accepted line into its complete expected waveform.
   task automatic schedule_line();
      int old_a = m_addr;
      int base  = (i_base_cycles == 0) ? 1 : int'(i_base_cycles);
      int n     = base << i_pix_bit;
      if (i_pix_bit == 0 && !m_first) m_addr = (m_addr + 1) % OUT_ROWS;
      m_first = 0;
      repeat (DEAD) exp_q.push_back(mk(1, 0, 0, 0, old_a, 1));
      exp_q.push_back(mk(1, 1, 1, 0, old_a, 0));
      for (int i = 0; i < DEAD; i++) exp_q.push_back(mk(1, 0, 0, 0, m_addr, i != 0));
      repeat (n) exp_q.push_back(mk(0, 0, 0, 0, m_addr, 1));
   endtask

   // Inputs seen before each rising edge decide the outputs after it.
   initial begin
      exp_now = mk(1, 0, 0, 0, 0, 1);
      mode    = M_IDLE;
      m_first = 1;
      m_addr  = 0;
      forever begin
         logic uf;
         @(posedge clk);
         uf = 0;
         if (rst) begin
            exp_q.delete();
            mode    = M_IDLE;
            m_first = 1;
            m_addr  = 0;
            exp_now = mk(1, 0, 0, 0, 0, 1);
         end else if (exp_q.size() != 0) begin
            exp_now = exp_q.pop_front();
         end else begin
            case (mode)
               M_RUN: begin
                  if (!i_en) begin
                     mode    = M_IDLE;
                     m_first = 1;
                  end else if (i_line_valid) schedule_line();
                  else begin
                     mode = M_STALL;
                     uf   = 1;
                  end
               end
               M_IDLE:  if (i_en && i_line_valid) schedule_line();
               M_STALL: begin
                  if (i_en && i_line_valid) schedule_line();
                  else if (!i_en) mode = M_IDLE;
               end
               default: mode = M_IDLE;
            endcase
            if (exp_q.size() != 0) begin
               mode    = M_RUN;
               exp_now = exp_q.pop_front();
            end else begin
               exp_now = mk(1, 0, 0, uf, m_addr, 1);
            end
         end
      end
   end

   // -------------------------------------------------------------- compare
   initial forever begin
      @(negedge clk);
      check("oe_n",      o_oe_n,      exp_now.oe_n);
      check("blanking",  o_blanking,  exp_now.oe_n);
      check("lat",       o_lat,       exp_now.lat);
      check("line_ack",  o_line_ack,  exp_now.ack);
      check("underflow", o_underflow, exp_now.uf);
      if (exp_now.chk_addr) check("addr", o_addr, exp_now.addr);
   end

   // -------------------------------------------------------------- monitor
   int runs_q[$];
   int fall_addr_q[$];
   int uf_count;
   int lat_count;
   int run_len;
   bit in_run;

   initial begin
      uf_count = 0; lat_count = 0; run_len = 0; in_run = 0;
      forever begin
         @(negedge clk);
         if (o_oe_n == 1'b0) begin
            if (!in_run) begin
               in_run  = 1;
               run_len = 0;
               fall_addr_q.push_back(int'(o_addr));
            end
            run_len++;
         end else if (in_run) begin
            in_run = 0;
            runs_q.push_back(run_len);
         end
         if (o_underflow) uf_count++;
         if (o_lat)       lat_count++;
      end
   end

   function automatic int run_at(input int i);
      return (i < runs_q.size()) ? runs_q[i] : -1;
   endfunction

   function automatic int addr_at(input int i);
      return (i < fall_addr_q.size()) ? fall_addr_q[i] : -1;
   endfunction

   // ------------------------------------------------------------ stimulus
   task automatic do_reset();
      @(negedge clk);
      rst = 1; i_en = 0; i_line_valid = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      runs_q.delete(); fall_addr_q.delete();
      uf_count = 0; lat_count = 0; in_run = 0;
   endtask

   // Offer a line and wait for its acknowledge; inputs stay stable through
   // the edge after ack, as the datapath would hold them.
   task automatic send_line(input int b, input int base, input bit hold,
                            output int wait_cycles, output int lat_at_ack);
      bit got = 0;
      i_pix_bit     = 3'(b);
      i_base_cycles = 16'(base);
      i_line_valid  = 1;
      wait_cycles   = -1;
      lat_at_ack    = 0;
      for (int i = 1; i <= MAX_WAIT; i++) begin
         @(negedge clk);
         if (o_line_ack) begin
            got         = 1;
            wait_cycles = i;
            lat_at_ack  = int'(o_lat);
            break;
         end
      end
      if (!got) check("ack_wait", int'(got), 1);
      @(negedge clk);
      if (!hold) i_line_valid = 0;
   endtask

   task automatic wait_oe(input logic val, output int k);
      bit got = 0;
      k = -1;
      for (int i = 1; i <= MAX_WAIT; i++) begin
         @(negedge clk);
         if (o_oe_n == val) begin
            got = 1;
            k   = i;
            break;
         end
      end
      if (!got) check("oe_wait", int'(got), 1);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int w, l, k;
      bit prev_hold;
      rst = 1; i_en = 0; i_line_valid = 0; i_pix_bit = '0; i_base_cycles = '0;

      // Reset state
      do_reset();
      check("rst_oe_n",      o_oe_n,      1);
      check("rst_blanking",  o_blanking,  1);
      check("rst_lat",       o_lat,       0);
      check("rst_ack",       o_line_ack,  0);
      check("rst_underflow", o_underflow, 0);
      check("rst_addr",      o_addr,      0);

      // Basic timing: base 10, plane 0, valid held
      i_en = 1;
      send_line(0, 10, 1, w, l);
      check("t1_valid_to_lat", w, 5);
      check("t1_lat_with_ack", l, 1);
      wait_oe(0, k);
      check("t1_lat_to_oe_low", k + 1, 5);
      send_line(0, 10, 0, w, l);
      wait_oe(0, k);
      wait_oe(1, k);
      repeat (8) @(negedge clk);
      check("t1_on_time_0", run_at(0), 10);
      check("t1_on_time_1", run_at(1), 10);
      check("t4_underflow_pulses", uf_count, 1);
      check("t4_stall_oe_n", o_oe_n, 1);
      send_line(0, 10, 0, w, l);
      check("t4_relatch_latency", w, 5);
      wait_oe(0, k);
      wait_oe(1, k);
      repeat (4) @(negedge clk);
      check("t4_underflow_again", uf_count, 2);

      // 33 rows x 8 planes back to back, base 2: on-times and row wrap
      do_reset();
      i_en = 1;
      for (int r = 0; r < OUT_ROWS + 1; r++)
         for (int p = 0; p < 8; p++)
            send_line(p, 2, 1, w, l);
      i_line_valid = 0;
      wait_oe(0, k);
      wait_oe(1, k);
      repeat (4) @(negedge clk);
      check("t2_underflow_only_at_end", uf_count, 1);
      for (int i = 0; i < (OUT_ROWS + 1) * 8; i++) begin
         check("t2_on_time", run_at(i), 2 << (i % 8));
         check("t3_row_addr", addr_at(i), (i / 8) % OUT_ROWS);
      end

      // Base 0 behaves as 1: plane 3 lasts 8 cycles
      do_reset();
      i_en = 1;
      send_line(3, 0, 0, w, l);
      wait_oe(0, k);
      wait_oe(1, k);
      check("t5_base0_plane3", run_at(0), 8);

      // Reset in the middle of DISPLAY
      do_reset();
      i_en = 1;
      send_line(0, 4, 1, w, l);
      send_line(0, 4, 1, w, l);
      send_line(0, 4, 0, w, l);
      wait_oe(0, k);
      @(negedge clk);
      check("t6_addr_before_rst", o_addr, 2);
      rst = 1;
      @(negedge clk);
      check("t6_rst_oe_n", o_oe_n, 1);
      check("t6_rst_lat",  o_lat,  0);
      check("t6_rst_addr", o_addr, 0);
      rst = 0;

      // Enable dropped in POST_BLANK: one full display, then IDLE
      do_reset();
      i_en = 1;
      send_line(1, 3, 0, w, l);
      @(negedge clk);
      i_en = 0;
      i_line_valid = 1;
      wait_oe(0, k);
      wait_oe(1, k);
      repeat (30) @(negedge clk);
      check("t7_display_len",   run_at(0), 6);
      check("t7_no_underflow",  uf_count, 0);
      check("t7_single_latch",  lat_count, 1);
      check("t7_idle_oe_n",     o_oe_n, 1);
      i_line_valid = 0;

      // Randomised traffic against the model
      do_reset();
      i_en = 1;
      prev_hold = 0;
      for (int n = 0; n < 40; n++) begin
         bit hold = 1'($urandom_range(0, 1));
         if (!prev_hold) begin
            int gap = $urandom_range(0, 12);
            if ($urandom_range(0, 3) == 0) begin
               i_en = 0;
               repeat (gap + 1) @(negedge clk);
               i_en = 1;
            end else begin
               repeat (gap) @(negedge clk);
            end
         end
         send_line($urandom_range(0, 7), $urandom_range(0, 5), hold, w, l);
         prev_hold = hold;
      end
      i_line_valid = 0;
      repeat (800) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
